// File: rtl/pll_reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pll_reset_pkg
// Shared definitions for the PLL reset sequencer:
//   - seq_state_e : sequencer FSM states with fixed encodings
//   - STATE_W     : width of the exported state field
//   - default timing constants for the 120 MHz PLL clock
//   - cnt_w()     : width of a counter that must hold values 0..max_val
// Optional feature macro used by the sequencer: PLL_RESET_SEQ_LOSS_COUNTER_EN
// -----------------------------------------------------------------------------
package pll_reset_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } seq_state_e;

   // 10 us of stable lock at 120 MHz
   localparam int LOCK_HOLD_CYCLES_120MHZ   = 1200;
   localparam int SYNC_STAGES_DEFAULT        = 2;
   localparam int STAGE_GAP_CYCLES_DEFAULT   = 16;
   localparam int LOSS_FILTER_CYCLES_DEFAULT = 4;

   // Never returns less than 1 so degenerate counters stay legal vectors.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Generic single-bit synchroniser: SYNC_STAGES flops in series, cleared to 0
// by an asynchronous active-low reset. Intended for any slow asynchronous
// status flag entering the clk_i domain.
// Ports:
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset (clears every stage)
//   d_i    : asynchronous input flag
//   q_o    : synchronised flag, SYNC_STAGES edges of latency
// -----------------------------------------------------------------------------
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Holds downstream logic in reset until the PLL lock flag has been stable for
// LOCK_HOLD_CYCLES, then releases NUM_STAGES active-low resets one at a time,
// STAGE_GAP_CYCLES apart (bit 0 first). Once releasing or running, a lock
// dropout lasting LOSS_FILTER_CYCLES re-asserts every reset at once and is
// counted as a lock-loss event.
//
// Optional feature macro: PLL_RESET_SEQ_LOSS_COUNTER_EN
//   defined   : lock_loss_count counts loss events (saturating), loss_clear
//               zeroes it and wins over a simultaneous increment
//   undefined : lock_loss_count is tied to 0 and loss_clear is ignored
//
// Ports:
//   clock           : PLL output clock, the only clock
//   reset_n         : asynchronous active-low reset
//   pll_locked      : PLL lock flag, asynchronous to clock
//   loss_clear      : synchronous pulse, clears lock_loss_count
//   stage_reset_n   : registered active-low staged resets
//   ready           : registered, high in RUN with every stage released
//   state           : registered FSM state (0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 RUN)
//   lock_loss_count : saturating count of lock-loss events
// -----------------------------------------------------------------------------
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int SYNC_STAGES        = SYNC_STAGES_DEFAULT,
   parameter int LOCK_HOLD_CYCLES   = LOCK_HOLD_CYCLES_120MHZ,
   parameter int NUM_STAGES         = 3,
   parameter int STAGE_GAP_CYCLES   = STAGE_GAP_CYCLES_DEFAULT,
   parameter int LOSS_FILTER_CYCLES = LOSS_FILTER_CYCLES_DEFAULT,
   parameter int LOSS_CNT_W         = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  pll_locked,
   input  logic                  loss_clear,
   output logic [NUM_STAGES-1:0] stage_reset_n,
   output logic                  ready,
   output logic [STATE_W-1:0]    state,
   output logic [LOSS_CNT_W-1:0] lock_loss_count
);

   localparam int HOLD_W = cnt_w(LOCK_HOLD_CYCLES - 1);
   localparam int GAP_W  = cnt_w(STAGE_GAP_CYCLES - 1);
   localparam int IDX_W  = cnt_w(NUM_STAGES - 1);
   localparam int FILT_W = cnt_w(LOSS_FILTER_CYCLES);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLD_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);
   localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(LOSS_FILTER_CYCLES);

   logic                  locked_s;
   seq_state_e            state_q, state_d;
   logic [HOLD_W-1:0]     hold_q, hold_d;
   logic [GAP_W-1:0]      gap_q, gap_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [FILT_W-1:0]     filt_q, filt_d;
   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic                  ready_q, ready_d;
   logic                  loss_evt;

   sync_bit #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .d_i    (pll_locked),
      .q_o    (locked_s)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WAIT_LOCK;
         hold_q  <= '0;
         gap_q   <= '0;
         idx_q   <= '0;
         filt_q  <= '0;
         stage_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         filt_q  <= filt_d;
         stage_q <= stage_d;
         ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      gap_d    = gap_q;
      idx_d    = idx_q;
      filt_d   = filt_q;
      stage_d  = stage_q;
      ready_d  = ready_q;
      loss_evt = 1'b0;

      case (state_q)
         WAIT_LOCK: begin
            stage_d = '0;
            ready_d = 1'b0;
            filt_d  = '0;
            if (locked_s) begin
               state_d = HOLD;
               hold_d  = '0;
            end
         end

         HOLD: begin
            // A dropout before release only restarts the wait; it is not a loss.
            if (!locked_s) begin
               state_d = WAIT_LOCK;
               hold_d  = '0;
            end else if (hold_q == HOLD_LAST) begin
               state_d = RELEASE;
               stage_d = NUM_STAGES'(1);
               idx_d   = '0;
               gap_d   = '0;
               filt_d  = '0;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end

         RELEASE, RUN: begin
            if (filt_q == FILT_MAX) begin
               // Filtered loss: drop every stage together regardless of the
               // current lock sample.
               loss_evt = 1'b1;
               state_d  = WAIT_LOCK;
               stage_d  = '0;
               ready_d  = 1'b0;
               filt_d   = '0;
               hold_d   = '0;
               gap_d    = '0;
               idx_d    = '0;
            end else begin
               filt_d = locked_s ? '0 : (filt_q + FILT_W'(1));
               if (state_q == RELEASE) begin
                  if (idx_q == IDX_LAST) begin
                     state_d = RUN;
                     ready_d = 1'b1;
                  end else if (gap_q == GAP_LAST) begin
                     // Stages release in order, so stage_q is a thermometer
                     // code and the next stage is one more bit shifted in.
                     gap_d   = '0;
                     idx_d   = idx_q + IDX_W'(1);
                     stage_d = (stage_q << 1) | NUM_STAGES'(1);
                  end else begin
                     gap_d = gap_q + GAP_W'(1);
                  end
               end
            end
         end

         default: begin
            state_d = WAIT_LOCK;
            stage_d = '0;
            ready_d = 1'b0;
         end
      endcase
   end

   assign stage_reset_n = stage_q;
   assign ready         = ready_q;
   assign state         = state_q;

`ifdef PLL_RESET_SEQ_LOSS_COUNTER_EN
   logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

   always_comb begin
      loss_cnt_d = loss_cnt_q;
      if (loss_clear) begin
         loss_cnt_d = '0;
      end else if (loss_evt && (loss_cnt_q != '1)) begin
         loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         loss_cnt_q <= '0;
      end else begin
         loss_cnt_q <= loss_cnt_d;
      end
   end

   assign lock_loss_count = loss_cnt_q;
`else
   logic unused_loss_inputs;
   assign unused_loss_inputs = loss_clear | loss_evt;
   assign lock_loss_count    = '0;
`endif

endmodule
